// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Byte-write handshake between the CPU's MMIO block and the UART transmitter.
//   uart_w_enable : write strobe (master -> slave)
//   uart_w_data   : byte to transmit (master -> slave)
//   uart_w_ready  : transmitter can take a byte (slave -> master)
// A byte transfers on a clock edge where uart_w_enable && uart_w_ready.
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;
  logic       uart_w_enable;
  logic [7:0] uart_w_data;
  logic       uart_w_ready;

  modport master (
    output uart_w_enable,
    output uart_w_data,
    input  uart_w_ready
  );

  modport slave (
    input  uart_w_enable,
    input  uart_w_data,
    output uart_w_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Buffers bytes written by the CPU and serialises them as 8N1 frames
// (start bit, 8 data bits LSB first, stop bit) on the tx line.
//
// Ports:
//   clk        : system clock, all state on the rising edge
//   rst        : asynchronous reset, active low
//   wif        : byte-write handshake (slave side)
//   tx         : serial line, idle high, registered
//   busy       : high while a frame is on the line, registered
//   fifo_count : bytes queued, not counting the byte being shifted out
//   overflow   : sticky, set by a write attempt while the FIFO is full
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits sh[0..7] on the line, bit_idx selects the bit
// STOP  | stop bit (1); chains straight into START if a byte is queued
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_fifo_if.slave                 wif,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CPB    = CLK_FREQ / BAUD;
  localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          sh_q, sh_d;
  logic                tx_q, tx_d;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic                ovf_q;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic                push, pop, fifo_empty, bit_done;
  logic [7:0]          head;

  // Ready is purely a function of occupancy so CPU writes never stall on
  // an active frame.
  assign wif.uart_w_ready = (cnt_q != CNT_W'(FIFO_DEPTH));
  assign push             = wif.uart_w_enable && wif.uart_w_ready;
  assign fifo_empty       = (cnt_q == '0);
  assign head             = mem_q[rd_ptr_q];
  assign bit_done         = (baud_q == BAUD_W'(CPB - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = head;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = sh_q[0];
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = sh_q[bit_idx_d];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle bit between stop and next start.
            pop     = 1'b1;
            sh_d    = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != S_IDLE);
      cnt_q     <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wif.uart_w_enable && !wif.uart_w_ready) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wif.uart_w_data;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CLK_FREQ   = 100;
  localparam int BAUD       = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tx, busy, overflow;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo_if wif();

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wif       (wif),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one byte at a negedge; the next posedge is the accepting edge.
  // keep=1 means the bench expects this byte to appear on the line.
  task automatic wr(input logic [7:0] b, input bit keep);
    wif.uart_w_enable = 1'b1;
    wif.uart_w_data   = b;
    if (keep) exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Serial monitor: every frame is sampled on all 10*CPB cycles, so both
  // content and exact bit width are checked against the scoreboard head.
  initial begin
    logic       prev;
    logic [7:0] exp;
    logic [9:0] bits;
    bit         tok, aborted, had_exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        had_exp = (exp_q.size() != 0);
        if (had_exp) exp = exp_q.pop_front();
        else begin
          exp = 8'h00;
          chk("unexpected_frame", 32'd1, 32'd0);
        end
        tok     = 1'b1;
        aborted = 1'b0;
        bits    = '0;
        for (int j = 0; j < 10 * CPB; j++) begin
          if (j > 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            break;
          end
          if (j % CPB == 0) bits[j / CPB] = tx;
          else if (tx !== bits[j / CPB]) tok = 1'b0;
        end
        if (!aborted && had_exp)
          chk("frame {timing,start,stop,data}", 32'({tok, bits[0], bits[9], bits[8:1]}),
              32'({1'b1, 1'b0, 1'b1, exp}));
        prev = aborted ? 1'b1 : tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int maxc;
    bit active;
    wif.uart_w_enable = 1'b0;
    wif.uart_w_data   = 8'h00;
    rst               = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx),               32'd1);
    chk("rst_busy",  32'(busy),             32'd0);
    chk("rst_count", 32'(fifo_count),       32'd0);
    chk("rst_ovf",   32'(overflow),         32'd0);
    chk("rst_ready", 32'(wif.uart_w_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // 1: single byte, latency and frame length
    wr(8'h55, 1'b1);
    wif.uart_w_enable = 1'b0;
    chk("t1_count_after_accept", 32'(fifo_count), 32'd1);
    chk("t1_tx_still_high",      32'(tx),         32'd1);
    @(negedge clk);
    chk("t1_tx_low_2_edges", 32'(tx),         32'd0);
    chk("t1_busy_rise",      32'(busy),       32'd1);
    chk("t1_count_popped",   32'(fifo_count), 32'd0);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_len", 32'(n),    32'd100);
    chk("t1_tx_idle",  32'(tx),   32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // 2: two back-to-back frames, no gap
    wr(8'hA5, 1'b1);
    wr(8'h3C, 1'b1);
    wif.uart_w_enable = 1'b0;
    n = 0;
    while (busy && n < 600) begin
      n++;
      @(negedge clk);
    end
    chk("t2_busy_len", 32'(n), 32'd200);
    repeat (5) @(negedge clk);

    // 3: fill to capacity, 18th byte dropped
    for (int i = 0; i < 18; i++) begin
      wr(8'(i), i < 17);
      if (i == 16) begin
        chk("t3_count_full", 32'(fifo_count),       32'd16);
        chk("t3_ready_low",  32'(wif.uart_w_ready), 32'd0);
      end
    end
    wif.uart_w_enable = 1'b0;
    chk("t3_overflow",   32'(overflow),   32'd1);
    chk("t3_count_kept", 32'(fifo_count), 32'd16);
    wait_idle(2500);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    chk("t3_ovf_cleared", 32'(overflow), 32'd0);

    // 4: pointer wrap at low rate
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 37 + 5), 1'b1);
      wif.uart_w_enable = 1'b0;
      repeat (149) begin
        if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        @(negedge clk);
      end
    end
    chk("t4_max_count", 32'(maxc),     32'd1);
    chk("t4_overflow",  32'(overflow), 32'd0);
    wait_idle(300);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // 6: full FIFO, write attempt on the edge the next byte is popped
    for (int i = 0; i < 17; i++) wr(8'(8'h80 + i), 1'b1);
    wif.uart_w_enable = 1'b0;
    chk("t6_count_full", 32'(fifo_count), 32'd16);
    repeat (84) @(negedge clk);
    wif.uart_w_enable = 1'b1;
    wif.uart_w_data   = 8'hEE;
    chk("t6_ready_pre", 32'(wif.uart_w_ready), 32'd0);
    chk("t6_count_pre", 32'(fifo_count),       32'd16);
    @(negedge clk);
    wif.uart_w_enable = 1'b0;
    chk("t6_count_post", 32'(fifo_count),       32'd15);
    chk("t6_overflow",   32'(overflow),         32'd1);
    chk("t6_ready_post", 32'(wif.uart_w_ready), 32'd1);
    wait_idle(2000);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    do_reset();

    // 5: asynchronous reset mid-DATA with bytes queued
    wr(8'hFF, 1'b1);
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b0);
    wr(8'h03, 1'b0);
    wif.uart_w_enable = 1'b0;
    chk("t5_count_pre", 32'(fifo_count), 32'd3);
    repeat (40) @(negedge clk);
    chk("t5_tx_data_bit", 32'(tx), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_tx",    32'(tx),               32'd1);
    chk("t5_async_busy",  32'(busy),             32'd0);
    chk("t5_async_count", 32'(fifo_count),       32'd0);
    chk("t5_async_ready", 32'(wif.uart_w_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    active = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (!tx || busy) active = 1'b1;
    end
    chk("t5_quiet_after_rst", 32'(active), 32'd0);
    wr(8'h5A, 1'b1);
    wif.uart_w_enable = 1'b0;
    @(negedge clk);
    wait_idle(300);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmit endpoint on the device side of the CPU's UART write interface. It accepts bytes from the MMIO block over the uart_w_enable / uart_w_data / uart_w_ready handshake and buffers them in a FIFO. It then serialises each byte onto the tx line as 8N1: one start bit, 8 data bits LSB-first, one stop bit. It sits at top level between the mmio instance inside the single-cycle CPU and the board UART TX pin.

Parameters:
CLK_FREQ, 100000000, clk frequency in Hz
BAUD, 115200, line baud rate; CLKS_PER_BIT = CLK_FREQ / BAUD (integer division, must be >= 2)
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
uart_w_enable  input  1  write strobe from mmio; a byte is accepted on an edge where uart_w_enable && uart_w_ready
uart_w_data  input  8  byte to transmit, sampled with the accepting edge
uart_w_ready  output  1  FIFO not full (combinational from fifo count)
tx  output  1  serial line, idle high, registered
busy  output  1  1 while a frame is on the line (state != IDLE), registered
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes buffered, excluding the byte being shifted
overflow  output  1  sticky; set when uart_w_enable is asserted while uart_w_ready=0; cleared only by reset

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, fifo_count=0, overflow=0, uart_w_ready=1, state=IDLE, all pointers and counters 0. Any frame in progress is abandoned and the FIFO is emptied.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - Push on uart_w_enable && uart_w_ready.
  - Pop when the FSM loads a byte.
  - Push and pop on the same edge leaves fifo_count unchanged.
  - Write while full: data is dropped, FIFO is unchanged, overflow is set.
- FSM states:
  - IDLE -> START when fifo_count != 0. On that edge the head byte is popped into shift register sh[7:0], tx is driven 0, and baud_cnt=0.
  - START: after CLKS_PER_BIT cycles -> DATA, bit_idx=0, tx=sh[0].
  - DATA: every CLKS_PER_BIT cycles tx=sh[bit_idx+1]. After bit 7 has been held CLKS_PER_BIT cycles -> STOP, tx=1.
  - STOP: after CLKS_PER_BIT cycles:
    - if fifo_count != 0 -> START, popping the next byte with tx=0 on the same edge (no idle gap between frames);
    - otherwise -> IDLE.
- Bit timing: each bit, start and stop included, is exactly CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
- baud_cnt counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit transition.
- Latency: a byte pushed into an empty FIFO while IDLE appears as fifo_count=1 on the next cycle. tx falls 1 edge after that, i.e. 2 edges after the accepting edge.
- busy is 1 from the edge tx first falls until the edge the FSM returns to IDLE.
- uart_w_ready depends only on fifo_count, never on busy; CPU writes never stall while fewer than FIFO_DEPTH bytes are queued.
- Capacity: the byte in sh has left the FIFO, so up to FIFO_DEPTH+1 bytes can be outstanding.
- Arithmetic:
  - fifo_count is width $clog2(FIFO_DEPTH)+1 so it can represent FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Test Plan:
1. CLK_FREQ=100, BAUD=10 (10 clks/bit), rst pulse, write 0x55 once -> tx low 2 edges after accept. tx bit sequence 0,1,0,1,0,1,0,1,0,1, each exactly 10 cycles. busy high 100 cycles, then tx=1, busy=0.
2. Write 0xA5 then 0x3C on consecutive cycles -> frames 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1 with no idle cycle between; busy high 200 cycles continuously.
3. From idle, write 18 bytes 0x00..0x11 on consecutive cycles -> first popped, uart_w_ready drops after 17th accept with fifo_count=16. 18th dropped, overflow=1. Line carries 0x00..0x10 in order (17 frames, 1700 cycles).
4. Pointer wrap: send 40 bytes at 1 byte per 150 cycles -> all 40 received in order by a serial monitor, fifo_count never exceeds 1, overflow stays 0.
5. Assert rst=0 asynchronously mid-DATA of 0xFF with 3 bytes queued -> tx=1, busy=0, fifo_count=0 immediately, without waiting for a clock edge. After release, nothing is transmitted until a new write.
6. Full FIFO with simultaneous push on the edge a frame ends and the FSM pops -> uart_w_ready was 0, so the push is dropped, overflow=1, fifo_count goes 16->15.
